// File: rtl/spi_pkg.sv
// spi_pkg: FSM state encoding and default sizes for the SPI shift engine
package spi_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
   localparam int DW_DEF = 32;
   localparam int LW_DEF = 5;
endpackage

// File: rtl/spi_bit_cnt.sv
// spi_bit_cnt: clearable up-counter with a terminal-match output
module spi_bit_cnt #(
   parameter int W = 6
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic         i_inc,
   input  logic [W-1:0] i_term,
   output logic [W-1:0] o_cnt,
   output logic         o_match
);
   logic [W-1:0] r_cnt;
   always_ff @(posedge i_clk)
      r_cnt <= (i_rst || i_clr) ? '0 : r_cnt + W'(i_inc);
   assign o_cnt   = r_cnt;
   assign o_match = r_cnt == i_term;
endmodule

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI character shifter driven by external SCK edge flags.
// Define SPI_LOOPBACK_EN to let I_LOOP feed O_MOSI back into the receive path.
module spi_shift_engine
   import spi_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int LW = LW_DEF
) (
   input  logic          I_SYS_CLK,
   input  logic          I_RST,
   input  logic          I_EN,
   input  logic          I_START,
   input  logic          I_CPOL,
   input  logic          I_CPHA,
   input  logic          I_LSB_FIRST,
   input  logic [LW-1:0] I_LEN,
   input  logic [DW-1:0] I_TX_DATA,
   input  logic          I_POS_EDGE,
   input  logic          I_NEG_EDGE,
   input  logic          I_MISO,
   input  logic          I_LOOP,
   output logic          O_GO,
   output logic          O_LAST_CLK,
   output logic          O_MOSI,
   output logic          O_BUSY,
   output logic          O_DONE,
   output logic [DW-1:0] O_RX_DATA
);
   state_t        r_state;
   logic [DW-1:0] r_tx, r_rx_sh, r_rx;
   logic [LW-1:0] r_len;
   logic          r_cpol, r_cpha, r_lsb, r_go, r_busy, r_done, r_mosi;
   logic [LW:0]   w_cnt;
   logic          w_match, w_lead, w_trail, w_sample_edge, w_drive_edge, w_end, w_miso;
   logic [LW-1:0] w_idx, w_first;

   spi_bit_cnt #(.W(LW + 1)) u_cnt (
      .i_clk   (I_SYS_CLK),
      .i_rst   (I_RST),
      .i_clr   (r_state != SHIFT || !I_EN),
      .i_inc   (w_sample_edge),
      .i_term  ({1'b0, r_len}),
      .o_cnt   (w_cnt),
      .o_match (w_match)
   );

   // a simultaneous pair of flags is treated as the leading edge alone
   assign w_lead        = r_cpol ? I_NEG_EDGE : I_POS_EDGE;
   assign w_trail       = (r_cpol ? I_POS_EDGE : I_NEG_EDGE) && !w_lead;
   assign w_sample_edge = r_cpha ? w_trail : w_lead;
   assign w_drive_edge  = r_cpha ? w_lead : w_trail;
   assign w_idx         = r_lsb ? w_cnt[LW-1:0] : r_len - w_cnt[LW-1:0];
   assign w_first       = I_LSB_FIRST ? '0 : I_LEN;
   assign w_end         = r_cpha ? (w_sample_edge && w_match)
                                 : (w_drive_edge && w_cnt == {1'b0, r_len} + (LW + 1)'(1));
`ifdef SPI_LOOPBACK_EN
   assign w_miso = I_LOOP ? r_mosi : I_MISO;
`else
   assign w_miso = I_MISO | (I_LOOP & 1'b0);
`endif

   always_ff @(posedge I_SYS_CLK) begin
      if (I_RST) begin
         r_state <= IDLE;
         r_tx    <= '0;
         r_rx_sh <= '0;
         r_rx    <= '0;
         r_len   <= '0;
         r_cpol  <= 1'b0;
         r_cpha  <= 1'b0;
         r_lsb   <= 1'b0;
         r_go    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_mosi  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (!I_EN) begin
            r_state <= IDLE;
            r_go    <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               IDLE: if (I_START) begin
                  r_state <= SHIFT;
                  r_tx    <= I_TX_DATA;
                  r_len   <= I_LEN;
                  r_cpol  <= I_CPOL;
                  r_cpha  <= I_CPHA;
                  r_lsb   <= I_LSB_FIRST;
                  r_rx_sh <= '0;
                  r_go    <= 1'b1;
                  r_busy  <= 1'b1;
                  r_mosi  <= I_CPHA ? r_mosi : I_TX_DATA[w_first];
               end
               SHIFT: begin
                  if (w_sample_edge) r_rx_sh[w_idx] <= w_miso;
                  if (w_drive_edge && !w_end) r_mosi <= r_tx[w_idx];
                  if (w_end) begin
                     r_state <= DONE;
                     r_go    <= 1'b0;
                  end
               end
               DONE: begin
                  r_state <= IDLE;
                  r_rx    <= r_rx_sh;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign O_GO       = r_go;
   assign O_BUSY     = r_busy;
   assign O_DONE     = r_done;
   assign O_MOSI     = r_mosi;
   assign O_RX_DATA  = r_rx;
   assign O_LAST_CLK = r_state == SHIFT && w_match;
endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: directed scenarios with a queue scoreboard for MOSI bits and received words
module tb_spi_shift_engine;
   logic        clk = 1'b0;
   logic        I_RST = 1'b1, I_EN = 1'b1, I_START = 1'b0, I_CPOL = 1'b0, I_CPHA = 1'b0;
   logic        I_LSB_FIRST = 1'b0, I_POS_EDGE = 1'b0, I_NEG_EDGE = 1'b0, I_MISO = 1'b0, I_LOOP = 1'b0;
   logic [4:0]  I_LEN = '0;
   logic [31:0] I_TX_DATA = '0;
   logic        O_GO, O_LAST_CLK, O_MOSI, O_BUSY, O_DONE;
   logic [31:0] O_RX_DATA;

   int          checks = 0, errors = 0, done_cnt = 0;
   logic [31:0] exp_rx_q[$];
   logic        exp_mosi_q[$];
   logic        obs_mosi[$], obs_last[$];
   logic [31:0] last_rx = '0;
   logic        timed_out, ab_go, ab_busy;

   spi_shift_engine dut (
      .I_SYS_CLK(clk), .I_RST(I_RST), .I_EN(I_EN), .I_START(I_START), .I_CPOL(I_CPOL),
      .I_CPHA(I_CPHA), .I_LSB_FIRST(I_LSB_FIRST), .I_LEN(I_LEN), .I_TX_DATA(I_TX_DATA),
      .I_POS_EDGE(I_POS_EDGE), .I_NEG_EDGE(I_NEG_EDGE), .I_MISO(I_MISO), .I_LOOP(I_LOOP),
      .O_GO(O_GO), .O_LAST_CLK(O_LAST_CLK), .O_MOSI(O_MOSI), .O_BUSY(O_BUSY),
      .O_DONE(O_DONE), .O_RX_DATA(O_RX_DATA)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (O_DONE === 1'b1) done_cnt <= done_cnt + 1;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   // SCK-generator and slave model: alternating leading/trailing flags, MISO set before each sample edge
   task automatic drive_xfer(input bit cpol, input bit cpha, input bit lsb, input logic [4:0] len,
                             input logic [31:0] tx, input logic [31:0] miso_w,
                             input int abort_after, input bit poke);
      int k;
      bit is_lead, is_sample;
      k = 0;
      obs_mosi.delete();
      obs_last.delete();
      timed_out = 1'b1;
      I_CPOL = cpol; I_CPHA = cpha; I_LSB_FIRST = lsb; I_LEN = len; I_TX_DATA = tx; I_START = 1'b1;
      @(posedge clk); #1;
      I_START = 1'b0; I_CPOL = ~cpol; I_CPHA = ~cpha; I_LSB_FIRST = ~lsb; I_LEN = ~len; I_TX_DATA = ~tx;
      for (int e = 0; e < 200; e++) begin
         repeat (2) @(posedge clk);
         #1;
         is_lead = (e % 2 == 0);
         is_sample = (is_lead != cpha);
         if (is_sample) begin
            I_MISO = miso_w[lsb ? k : int'(len) - k];
            obs_mosi.push_back(O_MOSI);
            obs_last.push_back(O_LAST_CLK);
         end
         if (is_lead == !cpol) I_POS_EDGE = 1'b1; else I_NEG_EDGE = 1'b1;
         I_START = poke && e == 3;
         @(posedge clk); #1;
         I_POS_EDGE = 1'b0; I_NEG_EDGE = 1'b0; I_START = 1'b0;
         if (is_sample) k++;
         if (abort_after >= 0 && k == abort_after) begin
            I_EN = 1'b0;
            @(posedge clk); #1;
            ab_go = O_GO;
            ab_busy = O_BUSY;
            I_EN = 1'b1;
            timed_out = 1'b0;
            break;
         end
         if (!O_GO) begin
            timed_out = 1'b0;
            break;
         end
      end
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      int d0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({O_GO, O_BUSY, O_DONE, O_MOSI, O_LAST_CLK} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 00000", {O_GO, O_BUSY, O_DONE, O_MOSI, O_LAST_CLK});
      end
      checks++;
      if (O_RX_DATA !== 32'h0) begin
         errors++;
         $display("FAIL reset_rx: got %h expected 00000000", O_RX_DATA);
      end
      I_RST = 1'b0;
      @(posedge clk); #1;
      I_LEN = 5'd7; I_TX_DATA = 32'hFF; I_CPHA = 1'b0; I_LSB_FIRST = 1'b0; I_START = 1'b1;
      @(posedge clk); #1;
      I_START = 1'b0;
      checks++;
      if ({O_GO, O_BUSY, O_MOSI} !== 3'b111) begin
         errors++;
         $display("FAIL start_flags: got %b expected 111", {O_GO, O_BUSY, O_MOSI});
      end
      d0 = done_cnt;
      I_RST = 1'b1;
      @(posedge clk); #1;
      I_RST = 1'b0;
      checks++;
      if ({O_GO, O_BUSY, O_MOSI} !== 3'b000) begin
         errors++;
         $display("FAIL reset_abort_flags: got %b expected 000", {O_GO, O_BUSY, O_MOSI});
      end
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (done_cnt !== d0) begin
         errors++;
         $display("FAIL reset_abort_done: got %0d pulses expected 0", done_cnt - d0);
      end
   endtask

   task automatic test_mode0;
      int d0;
      logic [31:0] tx = 32'hA5;
      logic e, o, r;
      d0 = done_cnt;
      for (int k = 0; k < 8; k++) exp_mosi_q.push_back(tx[7 - k]);
      exp_rx_q.push_back(32'h3C);
      drive_xfer(1'b0, 1'b0, 1'b0, 5'd7, tx, 32'h3C, -1, 1'b0);
      checks++;
      if (timed_out || obs_mosi.size() != 8) begin
         errors++;
         $display("FAIL mode0_bits: got %0d sampled bits (timeout %b) expected 8", obs_mosi.size(), timed_out);
      end
      for (int k = 0; exp_mosi_q.size() > 0; k++) begin
         e = exp_mosi_q.pop_front();
         o = obs_mosi.size() > 0 ? obs_mosi.pop_front() : 1'bx;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL mode0_mosi[%0d]: got %b expected %b", k, o, e);
         end
      end
      r = 1'b0;
      last_rx = exp_rx_q.pop_front();
      checks++;
      if (O_RX_DATA !== last_rx) begin
         errors++;
         $display("FAIL mode0_rx: got %h expected %h", O_RX_DATA, last_rx);
      end
      checks++;
      if (done_cnt - d0 !== 1 || O_BUSY !== r) begin
         errors++;
         $display("FAIL mode0_done: got %0d pulses busy %b expected 1 pulses busy 0", done_cnt - d0, O_BUSY);
      end
   endtask

   task automatic test_abort;
      int d0;
      logic [31:0] tx = 32'hC3;
      logic e, o;
      d0 = done_cnt;
      for (int k = 0; k < 3; k++) exp_mosi_q.push_back(tx[7 - k]);
      drive_xfer(1'b0, 1'b0, 1'b0, 5'd7, tx, 32'hFF, 3, 1'b0);
      while (exp_mosi_q.size() > 0) begin
         e = exp_mosi_q.pop_front();
         o = obs_mosi.size() > 0 ? obs_mosi.pop_front() : 1'bx;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL abort_mosi: got %b expected %b", o, e);
         end
      end
      checks++;
      if (timed_out || {ab_go, ab_busy} !== 2'b00) begin
         errors++;
         $display("FAIL abort_flags: got go/busy %b%b (timeout %b) expected 00", ab_go, ab_busy, timed_out);
      end
      checks++;
      if (done_cnt !== d0) begin
         errors++;
         $display("FAIL abort_done: got %0d pulses expected 0", done_cnt - d0);
      end
      checks++;
      if (O_RX_DATA !== last_rx) begin
         errors++;
         $display("FAIL abort_rx: got %h expected %h", O_RX_DATA, last_rx);
      end
   endtask

   task automatic test_mode3;
      int d0;
      logic [31:0] tx = 32'hDEADBEEF;
      logic e, o;
      d0 = done_cnt;
      for (int k = 0; k < 32; k++) exp_mosi_q.push_back(tx[k]);
      exp_rx_q.push_back(32'hDEADBEEF);
      drive_xfer(1'b1, 1'b1, 1'b1, 5'd31, tx, tx, -1, 1'b0);
      checks++;
      if (timed_out || obs_last.size() != 32) begin
         errors++;
         $display("FAIL mode3_bits: got %0d sampled bits (timeout %b) expected 32", obs_last.size(), timed_out);
      end
      for (int k = 0; k < obs_last.size(); k++) begin
         checks++;
         if (obs_last[k] !== (k == 31)) begin
            errors++;
            $display("FAIL mode3_last_clk[%0d]: got %b expected %b", k, obs_last[k], k == 31);
         end
      end
      for (int k = 0; exp_mosi_q.size() > 0; k++) begin
         e = exp_mosi_q.pop_front();
         o = obs_mosi.size() > 0 ? obs_mosi.pop_front() : 1'bx;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL mode3_mosi[%0d]: got %b expected %b", k, o, e);
         end
      end
      last_rx = exp_rx_q.pop_front();
      checks++;
      if (O_RX_DATA !== last_rx) begin
         errors++;
         $display("FAIL mode3_rx: got %h expected %h", O_RX_DATA, last_rx);
      end
      checks++;
      if (done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL mode3_done: got %0d pulses expected 1", done_cnt - d0);
      end
   endtask

   task automatic test_len0;
      int d0;
      logic o;
      d0 = done_cnt;
      exp_mosi_q.push_back(1'b1);
      exp_rx_q.push_back(32'h0);
      drive_xfer(1'b0, 1'b1, 1'b0, 5'd0, 32'h1, 32'h0, -1, 1'b0);
      checks++;
      if (timed_out || obs_mosi.size() != 1 || obs_last[0] !== 1'b1) begin
         errors++;
         $display("FAIL len0_bits: got %0d bits (timeout %b) expected 1 with last_clk", obs_mosi.size(), timed_out);
      end
      o = obs_mosi.size() > 0 ? obs_mosi.pop_front() : 1'bx;
      checks++;
      if (o !== exp_mosi_q.pop_front()) begin
         errors++;
         $display("FAIL len0_mosi: got %b expected 1", o);
      end
      last_rx = exp_rx_q.pop_front();
      checks++;
      if (O_RX_DATA !== last_rx) begin
         errors++;
         $display("FAIL len0_rx: got %h expected %h", O_RX_DATA, last_rx);
      end
      checks++;
      if (done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL len0_done: got %0d pulses expected 1", done_cnt - d0);
      end
   endtask

   task automatic test_back_to_back;
      int d0;
      logic [31:0] tx = 32'h96;
      logic [31:0] tx2 = 32'hABC;
      logic e, o;
      d0 = done_cnt;
      for (int k = 0; k < 8; k++) exp_mosi_q.push_back(tx[7 - k]);
      exp_rx_q.push_back(32'h69);
      drive_xfer(1'b0, 1'b1, 1'b0, 5'd7, tx, 32'h69, -1, 1'b1);
      while (exp_mosi_q.size() > 0) begin
         e = exp_mosi_q.pop_front();
         o = obs_mosi.size() > 0 ? obs_mosi.pop_front() : 1'bx;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL b2b_mode1_mosi: got %b expected %b", o, e);
         end
      end
      last_rx = exp_rx_q.pop_front();
      checks++;
      if (timed_out || O_RX_DATA !== last_rx) begin
         errors++;
         $display("FAIL b2b_mode1_rx: got %h (timeout %b) expected %h", O_RX_DATA, timed_out, last_rx);
      end
      checks++;
      if (done_cnt - d0 !== 1 || O_BUSY !== 1'b0) begin
         errors++;
         $display("FAIL b2b_ignored_start: got %0d pulses busy %b expected 1 pulses busy 0", done_cnt - d0, O_BUSY);
      end
      for (int k = 0; k < 12; k++) exp_mosi_q.push_back(tx2[k]);
      exp_rx_q.push_back(32'h5A5);
      drive_xfer(1'b1, 1'b0, 1'b1, 5'd11, tx2, 32'h5A5, -1, 1'b0);
      while (exp_mosi_q.size() > 0) begin
         e = exp_mosi_q.pop_front();
         o = obs_mosi.size() > 0 ? obs_mosi.pop_front() : 1'bx;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL b2b_mode2_mosi: got %b expected %b", o, e);
         end
      end
      last_rx = exp_rx_q.pop_front();
      checks++;
      if (timed_out || O_RX_DATA !== last_rx) begin
         errors++;
         $display("FAIL b2b_mode2_rx: got %h (timeout %b) expected %h", O_RX_DATA, timed_out, last_rx);
      end
      checks++;
      if (done_cnt - d0 !== 2) begin
         errors++;
         $display("FAIL b2b_done: got %0d pulses expected 2", done_cnt - d0);
      end
   endtask

   task automatic test_loopback;
      I_LOOP = 1'b1;
`ifdef SPI_LOOPBACK_EN
      exp_rx_q.push_back(32'h5A);
`else
      exp_rx_q.push_back(32'h0);
`endif
      drive_xfer(1'b0, 1'b0, 1'b0, 5'd7, 32'h5A, 32'h0, -1, 1'b0);
      I_LOOP = 1'b0;
      last_rx = exp_rx_q.pop_front();
      checks++;
      if (timed_out || O_RX_DATA !== last_rx) begin
         errors++;
         $display("FAIL loopback_rx: got %h (timeout %b) expected %h", O_RX_DATA, timed_out, last_rx);
      end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_abort();
      test_mode3();
      test_len0();
      test_back_to_back();
      test_loopback();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
